// File: rtl/freq_meter_if.sv
// Signal bundle between a frequency meter and the logic that drives and reads it.
// The meter itself uses the slave modport; the controlling side uses master.
interface freq_meter_if #(
    parameter int CNT_WIDTH = 24,
    parameter int HI_WIDTH  = 24
);
    logic                 sig_in;
    logic                 start;
    logic                 continuous;
    logic [CNT_WIDTH-1:0] freq_out;
    logic [HI_WIDTH-1:0]  high_out;
    logic                 overflow;
    logic                 valid;
    logic                 busy;

    modport master (
        output sig_in,
        output start,
        output continuous,
        input  freq_out,
        input  high_out,
        input  overflow,
        input  valid,
        input  busy
    );

    modport slave (
        input  sig_in,
        input  start,
        input  continuous,
        output freq_out,
        output high_out,
        output overflow,
        output valid,
        output busy
    );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency / duty meter: counts synchronized rising edges and high cycles of
// sig_in over GATE_CYCLES clk cycles and publishes the totals with a one-cycle strobe.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 32'd12_000_000,
    parameter int          CNT_WIDTH   = 24,
    parameter int          HI_WIDTH    = 24,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    freq_meter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [HI_WIDTH-1:0]  GATE_LAST = HI_WIDTH'(GATE_CYCLES - 32'd1);
    localparam logic [HI_WIDTH-1:0]  HI_ONE    = HI_WIDTH'(32'd1);
    localparam logic [HI_WIDTH-1:0]  HI_ZERO   = {HI_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] EDGE_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] EDGE_ONE  = CNT_WIDTH'(32'd1);
    localparam logic [CNT_WIDTH-1:0] EDGE_ZERO = {CNT_WIDTH{1'b0}};

    // Saturating edge-count step: returns {attempted_increment_at_max, next_count}.
    function automatic logic [CNT_WIDTH:0] edge_step(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc
    );
        logic [CNT_WIDTH:0] res;
        if (!inc) begin
            res = {1'b0, cnt};
        end else if (cnt == EDGE_MAX) begin
            res = {1'b1, cnt};
        end else begin
            res = {1'b0, cnt + EDGE_ONE};
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d_q;
    logic                   sig_s;
    logic                   rise_s;

    state_t               state_q,    state_d;
    logic [HI_WIDTH-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [HI_WIDTH-1:0]  high_cnt_q, high_cnt_d;
    logic                 ovf_q,      ovf_d;

    logic [CNT_WIDTH-1:0] freq_q,     freq_d;
    logic [HI_WIDTH-1:0]  high_q,     high_d;
    logic                 overflow_q, overflow_d;
    logic                 valid_q,    valid_d;
    logic                 busy_q,     busy_d;

    logic [CNT_WIDTH:0]   edge_step_s;

    // Synchronizer chain plus edge-detect delay flop; runs in every FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            sig_d_q <= sig_s;
        end
    end

    assign sig_s       = sync_q[SYNC_STAGES-1];
    assign rise_s      = sig_s & ~sig_d_q;
    assign edge_step_s = edge_step(edge_cnt_q, rise_s);

    // Next-state, counter and publish logic.
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        high_cnt_d = high_cnt_q;
        ovf_d      = ovf_q;
        freq_d     = freq_q;
        high_d     = high_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start | bus.continuous) begin
                    gate_cnt_d = HI_ZERO;
                    edge_cnt_d = EDGE_ZERO;
                    high_cnt_d = HI_ZERO;
                    ovf_d      = 1'b0;
                    state_d    = ST_GATE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_GATE: begin
                gate_cnt_d = gate_cnt_q + HI_ONE;
                edge_cnt_d = edge_step_s[CNT_WIDTH-1:0];
                ovf_d      = ovf_q | edge_step_s[CNT_WIDTH];
                if (sig_s) begin
                    high_cnt_d = high_cnt_q + HI_ONE;
                end else begin
                    high_cnt_d = high_cnt_q;
                end
                // Results are loaded on the way into DONE so they appear with valid.
                if (gate_cnt_q == GATE_LAST) begin
                    freq_d     = edge_cnt_d;
                    high_d     = high_cnt_d;
                    overflow_d = ovf_d;
                    valid_d    = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d    = ST_GATE;
                end
            end
            ST_DONE: begin
                if (bus.continuous) begin
                    gate_cnt_d = HI_ZERO;
                    edge_cnt_d = EDGE_ZERO;
                    high_cnt_d = HI_ZERO;
                    ovf_d      = 1'b0;
                    state_d    = ST_GATE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_GATE) || (state_d == ST_DONE);
    end

    // State, counters and published results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= HI_ZERO;
            edge_cnt_q <= EDGE_ZERO;
            high_cnt_q <= HI_ZERO;
            ovf_q      <= 1'b0;
            freq_q     <= EDGE_ZERO;
            high_q     <= HI_ZERO;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            high_cnt_q <= high_cnt_d;
            ovf_q      <= ovf_d;
            freq_q     <= freq_d;
            high_q     <= high_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.freq_out = freq_q;
    assign bus.high_out = high_q;
    assign bus.overflow = overflow_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;

endmodule
